alu_share_arbiter: RTL and testbench

- Shares one l_unit instance between NUM_REQ requesters, e.g. the execute stage and a multi-cycle mul/div or address-generation helper.
- Each requester uses a valid/ready handshake.
- Round-robin arbitration, one registered output stage, and the result is tagged with the requester id.
- Sits between the issue logic and the single ALU in the processor datapath.

---
 rtl/alu_share_arbiter_pkg.sv | 20 ++
 rtl/alu_share_arbiter_rr_arbiter.sv | 41 ++++
 rtl/l_unit.sv | 27 ++
 rtl/alu_share_arbiter.sv | 116 +++++++++++
 tb/tb_alu_share_arbiter.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// rtl/alu_share_arbiter_pkg.sv - shared ALU op constants and request bundle type
package alu_share_arbiter_pkg;

  localparam logic [3:0] OP_AND       = 4'h0;
  localparam logic [3:0] OP_OR        = 4'h1;
  localparam logic [3:0] OP_ADD       = 4'h2;
  localparam logic [3:0] OP_SRL       = 4'h3;
  localparam logic [3:0] OP_SLL       = 4'h4;
  localparam logic [3:0] OP_SRA       = 4'h5;
  localparam logic [3:0] OP_SUB       = 4'h6;
  localparam logic [3:0] OP_LESS_THAN = 4'h7;
  localparam logic [3:0] OP_XOR       = 4'h8;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } alu_req_t;

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// rtl/alu_share_arbiter_rr_arbiter.sv - round-robin arbiter searching from i_ptr+1 with wrap
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_winner,
  output logic               o_any
);

  logic            w_found;
  logic [ID_W-1:0] w_win;

  // Walk distances from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i_req[i] && (i == ((int'(i_ptr) + k) % NUM_REQ))) begin
          w_found = 1'b1;
          w_win   = ID_W'(i);
        end
      end
    end
  end

  always_comb begin
    o_grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      o_grant[i] = i_en && w_found && (w_win == ID_W'(i));
    end
  end

  assign o_winner = w_win;
  assign o_any    = w_found;

endmodule

// File: rtl/l_unit.sv
// rtl/l_unit.sv - combinational 32-bit ALU; unknown op codes fall back to ADD
module l_unit
  import alu_share_arbiter_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_result
);

  always_comb begin
    o_result = i_a + i_b;
    case (i_op)
      OP_AND:       o_result = i_a & i_b;
      OP_OR:        o_result = i_a | i_b;
      OP_ADD:       o_result = i_a + i_b;
      OP_SUB:       o_result = i_a - i_b;
      OP_LESS_THAN: o_result = {31'b0, $signed(i_a) < $signed(i_b)};
      OP_SRL:       o_result = i_a >> i_b[4:0];
      OP_SLL:       o_result = i_a << i_b[4:0];
      OP_SRA:       o_result = $unsigned($signed(i_a) >>> i_b[4:0]);
      OP_XOR:       o_result = i_a ^ i_b;
      default:      o_result = i_a + i_b;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one l_unit among NUM_REQ requesters, registered id-tagged result
// Optional per-requester grant/stall counters when ALU_ARB_PERF_EN is defined.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*4-1:0] req_op,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [31:0]          rsp_result
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0] perf_grant,
  output logic [NUM_REQ*32-1:0] perf_stall
`endif
);

  logic              r_rsp_valid;
  logic [ID_W-1:0]   r_rsp_id;
  logic [31:0]       r_rsp_result;
  logic [ID_W-1:0]   r_rr_last;

  alu_req_t          w_req [NUM_REQ];
  alu_req_t          w_sel;
  logic              w_can_load;
  logic              w_en;
  logic              w_any;
  logic              w_fire;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]   w_winner;
  logic [31:0]       w_alu_result;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_req[i].op = req_op[i*4 +: 4];
      w_req[i].a  = req_a[i*32 +: 32];
      w_req[i].b  = req_b[i*32 +: 32];
    end
  end

  // Holding rst blocks grants so no request is consumed during reset.
  assign w_can_load = !r_rsp_valid || rsp_ready;
  assign w_en       = w_can_load && !rst;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .i_req    (req_valid),
    .i_ptr    (r_rr_last),
    .i_en     (w_en),
    .o_grant  (w_grant),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  assign w_sel  = w_req[w_winner];
  assign w_fire = w_en && w_any;

  l_unit u_l_unit (
    .i_op     (w_sel.op),
    .i_a      (w_sel.a),
    .i_b      (w_sel.b),
    .o_result (w_alu_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
      r_rr_last    <= ID_W'(NUM_REQ - 1);
    end else if (w_fire) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_id     <= w_winner;
      r_rsp_result <= w_alu_result;
      r_rr_last    <= w_winner;
    end else if (rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  assign req_ready  = w_grant;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;

`ifdef ALU_ARB_PERF_EN
  logic [31:0] r_perf_grant [NUM_REQ];
  logic [31:0] r_perf_stall [NUM_REQ];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst) begin
        r_perf_grant[i] <= '0;
        r_perf_stall[i] <= '0;
      end else begin
        if (req_valid[i] && req_ready[i]) r_perf_grant[i] <= r_perf_grant[i] + 32'd1;
        if (req_valid[i] && !req_ready[i]) r_perf_stall[i] <= r_perf_stall[i] + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
    assign perf_grant[g*32 +: 32] = r_perf_grant[g];
    assign perf_stall[g*32 +: 32] = r_perf_stall[g];
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter (NUM_REQ=2)
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
`ifdef ALU_ARB_PERF_EN
  logic [63:0] perf_grant;
  logic [63:0] perf_stall;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NUM_REQ(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_grant (perf_grant),
    .perf_stall (perf_stall)
`endif
  );

  task automatic set_req(input int i, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid[i]      = v;
    req_op[i*4 +: 4]  = op;
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rsp_ready = 1'b1;
    set_req(0, 1'b1, OP_ADD, 32'd1, 32'd1);
    set_req(1, 1'b1, OP_ADD, 32'd2, 32'd2);
    step();
    step();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", rsp_result); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_id got %b want 0", rsp_id); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_first_grant got %b want 01", req_ready); end
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd2) begin
      errors++; $display("FAIL reset_first_rsp got v=%b id=%b r=%h want v=1 id=0 r=2", rsp_valid, rsp_id, rsp_result);
    end
    req_valid = 2'b00;
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_drain got %b want 0", rsp_valid); end
  endtask

  task automatic test_single_op();
    set_req(0, 1'b1, OP_ADD, 32'h7FFF_FFFF, 32'd1);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b want 01", req_ready); end
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'h8000_0000) begin
      errors++; $display("FAIL single_add got v=%b id=%b r=%h want v=1 id=0 r=80000000", rsp_valid, rsp_id, rsp_result);
    end
    set_req(0, 1'b1, OP_SRA, 32'h8000_0000, 32'd4);
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'hF800_0000) begin
      errors++; $display("FAIL single_sra got v=%b r=%h want v=1 r=f8000000", rsp_valid, rsp_result);
    end
    req_valid = 2'b00;
    step();
    checks++; if (rsp_valid !== 1'b0 || rsp_result !== 32'hF800_0000) begin
      errors++; $display("FAIL single_drain got v=%b r=%h want v=0 r=f8000000", rsp_valid, rsp_result);
    end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_gnt [4];
    logic        exp_id  [4];
    logic [31:0] exp_res [4];
    exp_gnt = '{2'b10, 2'b01, 2'b10, 2'b01};
    exp_id  = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_res = '{32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFE, 32'd1};
    set_req(0, 1'b1, OP_LESS_THAN, 32'hFFFF_FFFF, 32'd0);
    set_req(1, 1'b1, OP_SUB, 32'd3, 32'd5);
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (req_ready !== exp_gnt[k]) begin errors++; $display("FAIL contention_grant%0d got %b want %b", k, req_ready, exp_gnt[k]); end
      step();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id[k] || rsp_result !== exp_res[k]) begin
        errors++; $display("FAIL contention_rsp%0d got v=%b id=%b r=%h want v=1 id=%b r=%h", k, rsp_valid, rsp_id, rsp_result, exp_id[k], exp_res[k]);
      end
    end
    req_valid = 2'b00;
    step();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    set_req(0, 1'b1, OP_ADD, 32'd10, 32'd20);
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd30) begin
      errors++; $display("FAIL bp_load got v=%b id=%b r=%h want v=1 id=0 r=1e", rsp_valid, rsp_id, rsp_result);
    end
    set_req(1, 1'b1, OP_SUB, 32'd100, 32'd1);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready%0d got %b want 00", k, req_ready); end
      step();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd30) begin
        errors++; $display("FAIL bp_hold%0d got v=%b id=%b r=%h want v=1 id=0 r=1e", k, rsp_valid, rsp_id, rsp_result);
      end
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_release_grant got %b want 10", req_ready); end
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 32'd99) begin
      errors++; $display("FAIL bp_handoff got v=%b id=%b r=%h want v=1 id=1 r=63", rsp_valid, rsp_id, rsp_result);
    end
    req_valid = 2'b00;
    step();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    set_req(0, 1'b1, OP_AND, 32'hF0, 32'hFF);
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'hF0) begin
      errors++; $display("FAIL mid_load got v=%b id=%b r=%h want v=1 id=0 r=f0", rsp_valid, rsp_id, rsp_result);
    end
    rst = 1'b1;
    set_req(0, 1'b1, OP_OR, 32'hF0, 32'h0F);
    set_req(1, 1'b1, OP_XOR, 32'hF0, 32'hFF);
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL mid_rst_ready got %b want 00", req_ready); end
    step();
    checks++; if (rsp_valid !== 1'b0 || rsp_result !== 32'h0) begin
      errors++; $display("FAIL mid_drop got v=%b r=%h want v=0 r=0", rsp_valid, rsp_result);
    end
    rst = 1'b0;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_ptr got %b want 01", req_ready); end
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'hFF) begin
      errors++; $display("FAIL mid_after got v=%b id=%b r=%h want v=1 id=0 r=ff", rsp_valid, rsp_id, rsp_result);
    end
    req_valid = 2'b00;
    step();
  endtask

`ifdef ALU_ARB_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 1'b1, OP_ADD, 32'd1, 32'd2);
    for (int k = 0; k < 4; k++) step();
    rsp_ready = 1'b0;
    set_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
    set_req(1, 1'b1, OP_ADD, 32'd5, 32'd6);
    for (int k = 0; k < 3; k++) step();
    checks++; if (perf_grant[31:0] !== 32'd4) begin errors++; $display("FAIL perf_grant0 got %0d want 4", perf_grant[31:0]); end
    checks++; if (perf_stall[63:32] !== 32'd3) begin errors++; $display("FAIL perf_stall1 got %0d want 3", perf_stall[63:32]); end
    checks++; if (perf_grant[63:32] !== 32'd0 || perf_stall[31:0] !== 32'd0) begin
      errors++; $display("FAIL perf_others got g1=%0d s0=%0d want 0 0", perf_grant[63:32], perf_stall[31:0]);
    end
    rst = 1'b1;
    step();
    checks++; if (perf_grant !== 64'd0 || perf_stall !== 64'd0) begin
      errors++; $display("FAIL perf_clear got g=%h s=%h want 0 0", perf_grant, perf_stall);
    end
    rst = 1'b0;
    req_valid = 2'b00;
    step();
  endtask
`endif

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_reset_mid();
`ifdef ALU_ARB_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
